mpt_mem_stage: RTL

- Walking-stage memory access stage. It sits directly downstream of the forwarding buffer and consumes the MPT-entry address transactions that the buffer forwards.
- For each accepted transaction it issues one memory read for the MPTE, waits for the response, and hands the MPTE plus the echoed transaction to the next stage.
- On each successful fetch it sends an update back to the forwarding buffer's update slave port, so later transactions can reuse the result.
- One transaction is in flight at a time. A flush input and a response timeout are supported.

---
 rtl/mpt_mem_stage.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/mpt_mem_stage.sv
// MPT walk memory stage: fetches one MPTE per accepted transaction, returns it
// downstream and posts a best-effort update back to the forwarding buffer.
module mpt_mem_stage #(
  parameter int unsigned TRANSACTION_DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH             = 32,
  parameter int unsigned MPTE_WIDTH             = 64,
  parameter int unsigned TIMEOUT_CYCLES         = 255
) (
  input  logic                              clk_i,
  input  logic                              rst_ni,
  input  logic                              flush_i,
  input  logic                              fb_slave_stage_valid_i,
  output logic                              fb_slave_stage_ready_o,
  input  logic [TRANSACTION_DATA_WIDTH-1:0] fb_slave_stage_data_i,
  output logic                              out_master_stage_valid_o,
  input  logic                              out_master_stage_ready_i,
  output logic [TRANSACTION_DATA_WIDTH-1:0] out_master_stage_data_o,
  output logic [MPTE_WIDTH-1:0]             out_mpte_o,
  output logic                              out_err_o,
  output logic                              out_timeout_o,
  output logic                              fb_update_valid_o,
  input  logic                              fb_update_ready_i,
  output logic [TRANSACTION_DATA_WIDTH-1:0] fb_update_data_o,
  output logic                              mem_req_valid_o,
  input  logic                              mem_req_ready_i,
  output logic [ADDR_WIDTH-1:0]             mem_req_addr_o,
  input  logic                              mem_rsp_valid_i,
  input  logic [MPTE_WIDTH-1:0]             mem_rsp_data_i,
  input  logic                              mem_rsp_err_i
);

  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {IDLE, REQ, WAIT, RESP, DRAIN} state_e;

  state_e                            state_q, state_d;
  logic [TRANSACTION_DATA_WIDTH-1:0] payload_q, payload_d;
  logic [CW-1:0]                     cnt_q, cnt_d;
  logic [MPTE_WIDTH-1:0]             mpte_q, mpte_d;
  logic                              err_q, err_d;
  logic                              to_q, to_d;
  logic                              upd_q, upd_d;
  logic [CW-1:0]                     cnt_inc;
  logic                              expired;

  // The update is only a hint, so its ready never influences the stage.
  logic unused_fb_update_ready;
  assign unused_fb_update_ready = fb_update_ready_i;

  assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
  assign expired = (cnt_q >= CNT_LAST);

  always_comb begin
    state_d   = state_q;
    payload_d = payload_q;
    cnt_d     = cnt_q;
    mpte_d    = mpte_q;
    err_d     = err_q;
    to_d      = to_q;
    upd_d     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!flush_i && fb_slave_stage_valid_i) begin
          payload_d = fb_slave_stage_data_i;
          mpte_d    = '0;
          err_d     = 1'b0;
          to_d      = 1'b0;
          state_d   = REQ;
        end
      end
      REQ: begin
        if (flush_i) begin
          state_d = IDLE;
        end else if (mem_req_ready_i) begin
          cnt_d   = '0;
          state_d = WAIT;
        end
      end
      WAIT: begin
        cnt_d = cnt_inc;
        if (flush_i) begin
          state_d = DRAIN;
        end else if (mem_rsp_valid_i) begin
          // A response in the expiry cycle takes precedence over the timeout.
          mpte_d  = mem_rsp_err_i ? '0 : mem_rsp_data_i;
          err_d   = mem_rsp_err_i;
          to_d    = 1'b0;
          upd_d   = !mem_rsp_err_i;
          state_d = RESP;
        end else if (expired) begin
          mpte_d  = '0;
          err_d   = 1'b1;
          to_d    = 1'b1;
          state_d = RESP;
        end
      end
      RESP: begin
        if (flush_i || out_master_stage_ready_i) state_d = IDLE;
      end
      DRAIN: begin
        cnt_d = cnt_inc;
        if (mem_rsp_valid_i || expired) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      payload_q <= '0;
      cnt_q     <= '0;
      mpte_q    <= '0;
      err_q     <= 1'b0;
      to_q      <= 1'b0;
      upd_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      payload_q <= payload_d;
      cnt_q     <= cnt_d;
      mpte_q    <= mpte_d;
      err_q     <= err_d;
      to_q      <= to_d;
      upd_q     <= upd_d;
    end
  end

  assign fb_slave_stage_ready_o   = (state_q == IDLE) && !flush_i;
  assign mem_req_valid_o          = (state_q == REQ) && !flush_i;
  assign mem_req_addr_o           = payload_q[ADDR_WIDTH-1:0];
  assign out_master_stage_valid_o = (state_q == RESP) && !flush_i;
  assign out_master_stage_data_o  = payload_q;
  assign out_mpte_o               = mpte_q;
  assign out_err_o                = err_q;
  assign out_timeout_o            = to_q;
  assign fb_update_valid_o        = upd_q && !flush_i;
  assign fb_update_data_o         = payload_q;

endmodule
